// File: rtl/rf_pkg.sv
// Shared constants and sizing helper for the bypassed register file.
package rf_pkg;
  localparam int RF_DATA_W = 16;
  localparam int RF_NREGS  = 8;

  // Select width for n registers, never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rf_bank.sv
// Register storage: one write port, two combinational raw-read ports.
module rf_bank
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int ZERO_REG = 0,
  parameter int SEL_W    = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SEL_W-1:0]  wsel,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SEL_W-1:0]  rsel1,
  input  logic [SEL_W-1:0]  rsel2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREGS; i++)
        if (wsel == SEL_W'(i)) regs_q[i] <= wdata;
    end
  end

  // Unmatched selects (out of range or unknown) fall through to zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        if (rsel1 == SEL_W'(i)) rdata1 = regs_q[i];
        if (rsel2 == SEL_W'(i)) rdata2 = regs_q[i];
      end
    end
  end

endmodule

// File: rtl/rf_bypass_param.sv
// Two-read/one-write register file with write-to-read bypass, optional
// registered read stage, and illegal-select error flags.
module rf_bypass_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int ZERO_REG = 0,
  parameter int READ_LAT = 0,
  localparam int SEL_W   = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  readReg1Sel,
  input  logic [SEL_W-1:0]  readReg2Sel,
  input  logic [SEL_W-1:0]  writeRegSel,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEn,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              err,
  output logic              errSticky
);

  localparam logic [SEL_W:0] NREGS_W = (SEL_W+1)'(NREGS);

  logic              r1_ok, r2_ok, w_ok, wr_commit, err_c;
  logic [DATA_W-1:0] raw1, raw2, byp1, byp2;
  logic              sticky_q;

  // Range checks are written as if-defaults so an unknown select never
  // passes as legal: the condition evaluates false and the flag stays set.
  always_comb begin
    r1_ok = 1'b0;
    r2_ok = 1'b0;
    w_ok  = 1'b0;
    if ({1'b0, readReg1Sel} < NREGS_W) r1_ok = 1'b1;
    if ({1'b0, readReg2Sel} < NREGS_W) r2_ok = 1'b1;
    if ({1'b0, writeRegSel} < NREGS_W) w_ok  = 1'b1;

    err_c = 1'b1;
    if (r1_ok && r2_ok && (w_ok || writeEn == 1'b0)) err_c = 1'b0;

    wr_commit = 1'b0;
    if (writeEn && w_ok && !(ZERO_REG != 0 && writeRegSel == '0))
      wr_commit = 1'b1;

    byp1 = raw1;
    byp2 = raw2;
    if (wr_commit && readReg1Sel == writeRegSel) byp1 = writeData;
    if (wr_commit && readReg2Sel == writeRegSel) byp2 = writeData;
  end

  rf_bank #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .SEL_W    (SEL_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_commit),
    .wsel   (writeRegSel),
    .wdata  (writeData),
    .rsel1  (readReg1Sel),
    .rsel2  (readReg2Sel),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

  if (READ_LAT == 1) begin : g_lat1
    logic [DATA_W-1:0] rd1_q, rd2_q;
    logic              err_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd1_q <= '0;
        rd2_q <= '0;
        err_q <= 1'b0;
      end else begin
        rd1_q <= byp1;
        rd2_q <= byp2;
        err_q <= err_c;
      end
    end

    assign readData1 = rd1_q;
    assign readData2 = rd2_q;
    assign err       = err_q;
  end else begin : g_lat0
    assign readData1 = byp1;
    assign readData2 = byp2;
    assign err       = err_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       sticky_q <= 1'b0;
    else if (err_c) sticky_q <= 1'b1;
  end

  assign errSticky = sticky_q;

endmodule
